// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and framing constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        SUM   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] ST_HDR   = HDR;
    localparam logic [2:0] ST_LOAD  = LOAD;
    localparam logic [2:0] ST_WRITE = WRITE;
    localparam logic [2:0] ST_SUM   = SUM;
    localparam logic [2:0] ST_DONE  = DONE;
    localparam logic [2:0] ST_ERR   = ERR;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, instruction RAM write port and core control out
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_wa;
    logic [31:0]       imem_wd;
    logic              cpu_reset;
    logic              done;
    logic              error;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_wa, imem_wd, cpu_reset, done, error
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_wa, imem_wd, cpu_reset, done, error
    );
endinterface

// File: rtl/imem_loader_word_asm.sv
// loader_word_asm: big-endian byte-to-word assembler; word is combinational so the 4th byte is visible on its transfer edge
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);
    logic [23:0] word_q;
    logic [1:0]  cnt_q;

    assign word      = {word_q, byte_in};
    assign word_full = shift_en && cnt_q == 2'(BYTES_PER_WORD - 1);

    // Shift earlier bytes up; clear once the word is handed off so the next word starts clean
    always_ff @(posedge clk) begin
        if (reset || word_full) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift_en) begin
            word_q <= {word_q[15:0], byte_in};
            cnt_q  <= cnt_q + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a header-framed program into the instruction RAM, then releases the core; IMEM_LOADER_CHECKSUM_EN adds an XOR trailer byte check
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]       wd_q, wd_d, word;
    logic [ADDR_W:0]   hdr_words;
    logic              xfer, shift_en, word_full, last, hdr_bad;

    assign bus.in_ready = !reset && (state_q == ST_HDR || state_q == ST_LOAD || state_q == ST_SUM);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign shift_en     = xfer && state_q == ST_LOAD;
    assign hdr_bad      = int'(bus.in_data) > DEPTH;
    assign hdr_words    = bus.in_data == 8'd0 ? (ADDR_W + 1)'(DEPTH) : (ADDR_W + 1)'(bus.in_data);
    assign last         = {1'b0, idx_q} == cnt_q - 1'b1;
    assign wd_d         = word_full ? word : wd_q;

    assign bus.imem_we   = !reset && state_q == ST_WRITE;
    assign bus.imem_wa   = idx_q;
    assign bus.imem_wd   = wd_q;
    assign bus.cpu_reset = reset || state_q != ST_DONE;
    assign bus.done      = !reset && state_q == ST_DONE;
    assign bus.error     = !reset && state_q == ST_ERR;

    loader_word_asm u_asm (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .byte_in   (bus.in_data),
        .word      (word),
        .word_full (word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_TAIL = ST_SUM;
    logic [7:0] sum_q;

    // Running XOR of data bytes, restarted whenever a new header is awaited
    always_ff @(posedge clk) begin
        if (reset || state_q == ST_HDR)
            sum_q <= '0;
        else if (shift_en)
            sum_q <= sum_q ^ bus.in_data;
    end
`else
    localparam logic [2:0] ST_TAIL = ST_DONE;
`endif

    // Framing FSM: the last write holds its index so the address never wraps past the top word
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_HDR: begin
                if (xfer) begin
                    state_d = hdr_bad ? ST_ERR : ST_LOAD;
                    cnt_d   = hdr_words;
                end
            end
            ST_LOAD:  state_d = word_full ? ST_WRITE : ST_LOAD;
            ST_WRITE: begin
                state_d = last ? ST_TAIL : ST_LOAD;
                idx_d   = last ? idx_q : idx_q + 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_SUM:   state_d = !xfer ? ST_SUM : (bus.in_data == sum_q ? ST_DONE : ST_ERR);
`endif
            default:  state_d = state_q;
        endcase
    end

    // State, word index, word count and the write-data holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HDR;
            idx_q   <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end
endmodule
